// File: rtl/ysyx_24100006_pipe_skid_pkg.sv
// Shared constants for the pipeline register/skid stages.
// Holds the occupancy encoding and the per-stage payload geometry.
// No logic; imported by the interface, entry and stage modules.
package ysyx_24100006_pipe_skid_pkg;

  // Occupancy encoding; also used directly as the stage state.
  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  // Generic defaults.
  localparam int DEF_WIDTH  = 64;
  localparam int DEF_CTRL_W = 16;

  // Stage geometry for the ID/EXE, EXE/MEM and MEM/WB pipeline registers.
  localparam int ID_EXE_WIDTH   = DEF_WIDTH;
  localparam int ID_EXE_CTRL_W  = DEF_CTRL_W;
  localparam int EXE_MEM_WIDTH  = DEF_WIDTH;
  localparam int EXE_MEM_CTRL_W = DEF_CTRL_W;
  localparam int MEM_WB_WIDTH   = DEF_WIDTH;
  localparam int MEM_WB_CTRL_W  = DEF_CTRL_W;

endpackage

// File: rtl/ysyx_24100006_pipe_skid_if.sv
// Handshake bundle of one pipeline stage: upstream, downstream, redirect.
// Wires only, no latency.
// slave = the stage itself, master = the environment driving it.
interface ysyx_24100006_pipe_skid_if #(
  parameter int WIDTH = ysyx_24100006_pipe_skid_pkg::DEF_WIDTH
) ();

  logic             flush_i;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;

  modport slave (
    input  flush_i, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );

  modport master (
    output flush_i, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

endinterface

// File: rtl/ysyx_24100006_pipe_entry.sv
// One payload slot: control bits reset/flush-cleared, data bits load-only.
// Latency: a load is visible on o_data after the next rising edge.
// No handshake; the owner decides when to load or clear.
module ysyx_24100006_pipe_entry
  import ysyx_24100006_pipe_skid_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int CTRL_W = DEF_CTRL_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [CTRL_W-1:0] r_ctrl;

  // Control field: cleared by reset or redirect, clear wins over load.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ctrl <= '0;
    end else if (i_clear) begin
      r_ctrl <= '0;
    end else if (i_load) begin
      r_ctrl <= i_data[CTRL_W-1:0];
    end
  end

  assign o_data[CTRL_W-1:0] = r_ctrl;

  generate
    if (CTRL_W < WIDTH) begin : g_payload
      logic [WIDTH-1:CTRL_W] r_payload;

      // Bulk payload: only written on a real transfer into this slot.
      always_ff @(posedge i_clk) begin
        if (i_load) begin
          r_payload <= i_data[WIDTH-1:CTRL_W];
        end
      end

      assign o_data[WIDTH-1:CTRL_W] = r_payload;
    end
  endgenerate

endmodule

// File: rtl/ysyx_24100006_pipe_skid.sv
// Pipeline stage: single register (SKID=0) or two-entry skid buffer (SKID=1).
// Latency: one cycle from acceptance to out_valid; full throughput at occupancy 1.
// Backpressure: SKID=0 in_ready is !main_valid|out_ready; SKID=1 it is registered !skid_valid.
module ysyx_24100006_pipe_skid
  import ysyx_24100006_pipe_skid_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int SKID   = 1
) (
  input logic                      clk,
  input logic                      reset,
  ysyx_24100006_pipe_skid_if.slave bus
);

  // State value equals occupancy: EMPTY, ONE (main only), FULL (main+skid).
  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             w_main_vld;
  logic             w_in_rdy;
  logic             w_in_fire;
  logic             w_main_ld;
  logic             w_skid_ld;
  logic [WIDTH-1:0] w_main_d;
  logic [WIDTH-1:0] w_main_q;
  logic [WIDTH-1:0] w_skid_q;

  assign w_main_vld = (r_state != OCC_EMPTY);
  assign w_in_fire  = bus.in_valid & w_in_rdy;

  generate
    if (SKID != 0) begin : g_skid
      // Ready comes straight from the state flops, never from out_ready.
      assign w_in_rdy = (r_state != OCC_FULL);

      ysyx_24100006_pipe_entry #(
        .WIDTH  (WIDTH),
        .CTRL_W (CTRL_W)
      ) u_skid (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_load  (w_skid_ld),
        .i_clear (bus.flush_i),
        .i_data  (bus.in_data),
        .o_data  (w_skid_q)
      );
    end else begin : g_reg
      assign w_in_rdy = ~w_main_vld | bus.out_ready;
      assign w_skid_q = '0;
    end
  endgenerate

  // Next state and slot loads; redirect overrides every other event.
  // In SKID=0 an acceptance with main valid implies out_ready, so FULL is unreachable.
  always_comb begin
    w_state_nxt = r_state;
    w_main_ld   = 1'b0;
    w_skid_ld   = 1'b0;
    w_main_d    = bus.in_data;
    if (bus.flush_i) begin
      w_state_nxt = OCC_EMPTY;
    end else begin
      case (r_state)
        OCC_EMPTY: begin
          if (w_in_fire) begin
            w_main_ld   = 1'b1;
            w_state_nxt = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (w_in_fire) begin
            if (bus.out_ready) begin
              w_main_ld = 1'b1;
            end else begin
              w_skid_ld   = 1'b1;
              w_state_nxt = OCC_FULL;
            end
          end else if (bus.out_ready) begin
            w_state_nxt = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (bus.out_ready) begin
            w_main_ld   = 1'b1;
            w_main_d    = w_skid_q;
            w_state_nxt = OCC_ONE;
          end
        end
        default: begin
          w_state_nxt = OCC_EMPTY;
        end
      endcase
    end
  end

  // State register; reset aborts everything asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= OCC_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  ysyx_24100006_pipe_entry #(
    .WIDTH  (WIDTH),
    .CTRL_W (CTRL_W)
  ) u_main (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_load  (w_main_ld),
    .i_clear (bus.flush_i),
    .i_data  (w_main_d),
    .o_data  (w_main_q)
  );

  assign bus.in_ready  = w_in_rdy;
  assign bus.out_valid = w_main_vld & ~bus.flush_i;
  assign bus.out_data  = w_main_q;
  assign bus.occupancy = r_state;

endmodule

// File: doc/ysyx_24100006_pipe_skid.md
YSYX_24100006_PIPE_SKID -- requirements
Module: ysyx_24100006_pipe_skid

Interface
REQ-001 Parameter WIDTH, default 64: total payload bits carried per entry.
REQ-002 Parameter CTRL_W, default 16: low payload bits [CTRL_W-1:0] are control fields and are cleared on reset and flush; 1 <= CTRL_W <= WIDTH.
REQ-003 Parameter SKID, default 1: 0 = single-entry register stage; 1 = two-entry skid stage with registered in_ready.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 flush_i  input  1  redirect; discards all held entries this cycle.
REQ-007 in_valid  input  1  upstream entry valid.
REQ-008 in_ready  output  1  stage can accept an entry this cycle.
REQ-009 in_data  input  WIDTH  upstream payload.
REQ-010 out_valid  output  1  downstream entry valid.
REQ-011 out_ready  input  1  downstream accepts this cycle.
REQ-012 out_data  output  WIDTH  payload of the oldest held entry.
REQ-013 occupancy  output  2  number of held entries, 0..2.

Function
REQ-014 A transfer in occurs when in_valid & in_ready; a transfer out occurs when out_valid & out_ready.
REQ-015 out_valid SHALL equal main_valid & !flush_i; out_data SHALL be driven directly from the main register.
REQ-016 SKID=0: in_ready = !main_valid | out_ready (combinational); occupancy never exceeds 1.
REQ-017 SKID=0: on transfer in, main register loads in_data and main_valid <= 1; on transfer out without transfer in, main_valid <= 0; otherwise hold.
REQ-018 SKID=1: in_ready SHALL be the registered value !skid_valid, with no combinational path from out_ready.
REQ-019 SKID=1 states: EMPTY (occ 0), ONE (main only, occ 1), FULL (main+skid, occ 2).
REQ-020 EMPTY: transfer in -> ONE, payload into main.
REQ-021 ONE: in only -> if out_ready, main reloads (stay ONE); else payload into skid -> FULL. Out only -> EMPTY. Neither -> hold.
REQ-022 FULL: in_ready=0; on transfer out, skid moves to main, skid_valid <= 0 -> ONE; else hold.
REQ-023 Order SHALL be preserved: entries leave in exactly the order accepted; no entry dropped or duplicated absent flush.
REQ-024 Latency: an entry accepted in cycle N is presented on out_valid in cycle N+1 at the earliest.
REQ-025 flush_i has priority over every other event: next state EMPTY, main_valid and skid_valid <= 0, control bits of both entries <= 0, any same-cycle transfer in is discarded.
REQ-026 During flush in_ready keeps its normal value; upstream is also flushed by the same redirect and SHALL NOT rely on acceptance.
REQ-027 Data bits [WIDTH-1:CTRL_W] SHALL load only on a transfer into that entry and are otherwise held (not reset, not flushed).
REQ-028 Simultaneous in and out with occ 1 SHALL yield a back-to-back stream of one entry per cycle, for both SKID values.

Reset
REQ-029 While reset is low: main_valid=0, skid_valid=0, control bits=0, out_valid=0, occupancy=0; SKID=1 in_ready=1 (SKID=0 in_ready=1 via !main_valid).
REQ-030 Reset asserted mid-transfer SHALL abort it immediately and asynchronously; the first transfer in is possible in the first rising edge after deassertion.

Structure
REQ-031 A shared package SHALL hold the occupancy encoding constants (OCC_EMPTY=0, OCC_ONE=1, OCC_FULL=2) and the default WIDTH/CTRL_W values used by the ID/EXE, EXE/MEM and MEM/WB stages.
REQ-032 One sub-module ysyx_24100006_pipe_entry (WIDTH/CTRL_W storage with load, flush-clear of control bits, async reset) SHALL be instantiated once for main and, when SKID=1, once for skid.

Verification
REQ-033 SKID=1, out_ready=0, send A=0x11, B=0x22 -> occ 0->1->2, in_ready=0 after B; raise out_ready -> out_data 0x11 then 0x22, occ 2->1->0.
REQ-034 SKID=0 and SKID=1, in_valid and out_ready held 1 with 8 incrementing payloads -> 8 outputs in order, one per cycle after 1-cycle latency.
REQ-035 FULL state, assert flush_i with in_valid=1 data 0x33 -> out_valid=0 that cycle, occ=0 next cycle, 0x33 never appears, control bits read 0.
REQ-036 Drop reset low while occ=2 -> out_valid=0 and occupancy=0 before the next clock edge; after release, first accepted entry emerges unchanged.
REQ-037 Random in_valid/out_ready at 50% each, 1000 entries, SKID=1 -> scoreboard matches order, in_ready never depends combinationally on out_ready (checked by holding in_ready stable within each cycle).
